ct_writer: RTL

ARC4 encryptor that produces the length-prefixed ciphertext memory image consumed by `crack`. It reads a plaintext message from a plaintext memory, encrypts it with a 24-bit key, and writes the ciphertext into `ct_mem` through the memory's write port. It is the producer end of the `ct_mem` interface, whose reader is `crack`. Benches and on-chip self-test use it to generate cracking targets.

---
 rtl/arc4_pkg.sv | 36 +++
 rtl/arc4_sreg.sv | 37 +++
 rtl/ct_writer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/arc4_pkg.sv
// arc4_pkg: definitions shared by the ARC4 blocks (ct_writer, crack).
//   arc4_state_e  - top-level sequencer states
//   prga_phase_e  - sub-cycle phase used inside LEN and PRGA
//   KEY_BYTES     - key length in bytes
//   key_byte()    - key byte selected by (idx mod KEY_BYTES); byte 0 is key[23:16]
package arc4_pkg;

    localparam int unsigned KEY_BYTES = 3;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        KSA,
        LEN,
        PRGA
    } arc4_state_e;

    typedef enum logic [1:0] {
        PH_1,
        PH_2,
        PH_3
    } prga_phase_e;

    function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [7:0] idx);
        logic [7:0] sel;
        logic [7:0] b;
        sel = idx % 8'(KEY_BYTES);
        case (sel)
            8'd0:    b = key[23:16];
            8'd1:    b = key[15:8];
            default: b = key[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/arc4_sreg.sv
// arc4_sreg: 256x8 ARC4 state register file.
//   clk               - clock, rising edge
//   raddr_a/rdata_a   - combinational read port A
//   raddr_b/rdata_b   - combinational read port B
//   we/waddr/wdata    - single write port
//   swap/swap_a/swap_b- exchange two entries in one cycle (wins over write)
// No reset: contents are fully rewritten before they are ever read.
module arc4_sreg (
    input  logic       clk,
    input  logic [7:0] raddr_a,
    output logic [7:0] rdata_a,
    input  logic [7:0] raddr_b,
    output logic [7:0] rdata_b,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    input  logic       swap,
    input  logic [7:0] swap_a,
    input  logic [7:0] swap_b
);

    logic [7:0] mem_q [256];

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

    // Both non-blocking updates read the old values, so swap_a == swap_b is a no-op.
    always_ff @(posedge clk) begin
        if (swap) begin
            mem_q[swap_a] <= mem_q[swap_b];
            mem_q[swap_b] <= mem_q[swap_a];
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/ct_writer.sv
// ct_writer: ARC4 encryptor producing a length-prefixed ciphertext image.
//   clk, rst_n  - clock (rising edge), asynchronous active-low reset
//   en / rdy    - start request, accepted only while rdy=1
//   key         - 24-bit ARC4 key, captured at start
//   pt_addr     - plaintext RAM address (registered-address RAM, data next cycle)
//   pt_rddata   - plaintext RAM data
//   ct_addr, ct_wrdata, ct_wren - ciphertext RAM write port
//   cksum       - XOR of ciphertext bytes 1..L (only with CT_WRITER_CKSUM_EN)
// Optional feature macro: CT_WRITER_CKSUM_EN.
module ct_writer
    import arc4_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  pt_addr,
    input  logic [7:0]  pt_rddata,
    output logic [7:0]  ct_addr,
    output logic [7:0]  ct_wrdata,
    output logic        ct_wren
`ifdef CT_WRITER_CKSUM_EN
    ,
    output logic [7:0]  cksum
`endif
);

    arc4_state_e state_q, state_d;
    prga_phase_e ph_q, ph_d;
    logic [7:0]  i_q, i_d;
    logic [7:0]  j_q, j_d;
    logic [7:0]  t_q, t_d;
    logic [7:0]  len_q, len_d;
    logic [23:0] key_q, key_d;
    logic        rdy_q, rdy_d;
    logic [7:0]  pt_addr_q, pt_addr_d;
    logic [7:0]  ct_addr_q, ct_addr_d;
    logic [7:0]  ct_wrdata_q, ct_wrdata_d;
    logic        ct_wren_q, ct_wren_d;
`ifdef CT_WRITER_CKSUM_EN
    logic [7:0]  cksum_q, cksum_d;
`endif

    logic [7:0] s_raddr_a, s_rdata_a;
    logic [7:0] s_raddr_b, s_rdata_b;
    logic       s_we;
    logic [7:0] s_waddr, s_wdata;
    logic       s_swap;
    logic [7:0] s_swap_a, s_swap_b;

    arc4_sreg u_sreg (
        .clk     (clk),
        .raddr_a (s_raddr_a),
        .rdata_a (s_rdata_a),
        .raddr_b (s_raddr_b),
        .rdata_b (s_rdata_b),
        .we      (s_we),
        .waddr   (s_waddr),
        .wdata   (s_wdata),
        .swap    (s_swap),
        .swap_a  (s_swap_a),
        .swap_b  (s_swap_b)
    );

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        i_d         = i_q;
        j_d         = j_q;
        t_d         = t_q;
        len_d       = len_q;
        key_d       = key_q;
        rdy_d       = rdy_q;
        pt_addr_d   = pt_addr_q;
        ct_addr_d   = ct_addr_q;
        ct_wrdata_d = ct_wrdata_q;
        ct_wren_d   = 1'b0;
`ifdef CT_WRITER_CKSUM_EN
        cksum_d     = cksum_q;
`endif
        s_raddr_a   = i_q;
        s_raddr_b   = j_q;
        s_we        = 1'b0;
        s_waddr     = i_q;
        s_wdata     = i_q;
        s_swap      = 1'b0;
        s_swap_a    = i_q;
        s_swap_b    = j_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    key_d     = key;
                    i_d       = '0;
                    j_d       = '0;
                    rdy_d     = 1'b0;
                    pt_addr_d = '0;
                    state_d   = INIT;
`ifdef CT_WRITER_CKSUM_EN
                    cksum_d   = '0;
`endif
                end
            end

            INIT: begin
                s_we = 1'b1;
                i_d  = i_q + 8'd1;
                if (i_q == 8'hFF) begin
                    j_d     = '0;
                    state_d = KSA;
                end
            end

            KSA: begin
                // New j feeds the swap address in the same cycle.
                j_d      = j_q + s_rdata_a + key_byte(key_q, i_q);
                s_swap   = 1'b1;
                s_swap_b = j_d;
                i_d      = i_q + 8'd1;
                if (i_q == 8'hFF) begin
                    ph_d    = PH_1;
                    state_d = LEN;
                end
            end

            LEN: begin
                // pt_addr has been 0 since start, so length is on pt_rddata in cycle 2.
                if (ph_q == PH_1) begin
                    ph_d = PH_2;
                end else begin
                    ct_addr_d   = '0;
                    ct_wrdata_d = pt_rddata;
                    ct_wren_d   = 1'b1;
                    len_d       = pt_rddata;
                    i_d         = '0;
                    j_d         = '0;
                    pt_addr_d   = 8'd1;
                    ph_d        = PH_1;
                    if (pt_rddata == 8'd0) begin
                        rdy_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = PRGA;
                    end
                end
            end

            PRGA: begin
                case (ph_q)
                    PH_1: begin
                        s_raddr_a = i_q + 8'd1;
                        i_d       = i_q + 8'd1;
                        j_d       = j_q + s_rdata_a;
                        ph_d      = PH_2;
                    end
                    PH_2: begin
                        // The pad index S[i]+S[j] is unchanged by the swap, so it is
                        // captured here to leave a read port free for the pad lookup.
                        t_d    = s_rdata_a + s_rdata_b;
                        s_swap = 1'b1;
                        ph_d   = PH_3;
                    end
                    default: begin
                        s_raddr_a   = t_q;
                        ct_addr_d   = i_q;
                        ct_wrdata_d = pt_rddata ^ s_rdata_a;
                        ct_wren_d   = 1'b1;
`ifdef CT_WRITER_CKSUM_EN
                        cksum_d     = cksum_q ^ (pt_rddata ^ s_rdata_a);
`endif
                        ph_d        = PH_1;
                        if (i_q == len_q) begin
                            rdy_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            // Prefetch the next plaintext byte for its P1 cycle.
                            pt_addr_d = i_q + 8'd1;
                        end
                    end
                endcase
            end

            default: begin
                state_d = IDLE;
                rdy_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ph_q        <= PH_1;
            i_q         <= '0;
            j_q         <= '0;
            t_q         <= '0;
            len_q       <= '0;
            key_q       <= '0;
            rdy_q       <= 1'b1;
            pt_addr_q   <= '0;
            ct_addr_q   <= '0;
            ct_wrdata_q <= '0;
            ct_wren_q   <= 1'b0;
`ifdef CT_WRITER_CKSUM_EN
            cksum_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            i_q         <= i_d;
            j_q         <= j_d;
            t_q         <= t_d;
            len_q       <= len_d;
            key_q       <= key_d;
            rdy_q       <= rdy_d;
            pt_addr_q   <= pt_addr_d;
            ct_addr_q   <= ct_addr_d;
            ct_wrdata_q <= ct_wrdata_d;
            ct_wren_q   <= ct_wren_d;
`ifdef CT_WRITER_CKSUM_EN
            cksum_q     <= cksum_d;
`endif
        end
    end

    assign rdy       = rdy_q;
    assign pt_addr   = pt_addr_q;
    assign ct_addr   = ct_addr_q;
    assign ct_wrdata = ct_wrdata_q;
    assign ct_wren   = ct_wren_q;
`ifdef CT_WRITER_CKSUM_EN
    assign cksum     = cksum_q;
`endif

endmodule
